// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-side PC redirect unit: branch type
// encodings, redirect FSM states and default PC constants.
package pc_pkg;

  localparam logic [2:0] BR_BEQ  = 3'd0;
  localparam logic [2:0] BR_BNE  = 3'd1;
  localparam logic [2:0] BR_BGEZ = 3'd2;
  localparam logic [2:0] BR_BLTZ = 3'd3;
  localparam logic [2:0] BR_J    = 3'd4;
  localparam logic [2:0] BR_JR   = 3'd5;

  typedef enum logic {
    SEQ  = 1'b0,
    PEND = 1'b1
  } pc_state_t;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_PC_DEF   = 32'h0000_4180;

endpackage

// File: rtl/br_target_gen.sv
// Combinational branch/jump condition and target computation for the
// instruction currently in ID. Resolution gating (stall, br_valid) is left
// to the caller so this block stays a pure function of its inputs.
module br_target_gen
  import pc_pkg::*;
(
  input  logic [2:0]  br_type,
  input  logic        zero,
  input  logic        nonneg,
  input  logic [31:0] pc_d,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] rs_data,
  output logic        cond,
  output logic [31:0] target
);

  logic [31:0] pc_d_plus4;
  logic [31:0] br_offset;
  logic        unused_rs_low;

  assign pc_d_plus4    = pc_d + 32'd4;
  assign br_offset     = {{14{imm16[15]}}, imm16, 2'b00};
  // JR targets are forced word-aligned, so the low rs bits are dropped.
  assign unused_rs_low = ^rs_data[1:0];

  // Condition and target selection by branch type; reserved types never take.
  always_comb begin
    cond   = 1'b0;
    target = pc_d_plus4 + br_offset;
    case (br_type)
      BR_BEQ:  cond = zero;
      BR_BNE:  cond = !zero;
      BR_BGEZ: cond = nonneg;
      BR_BLTZ: cond = !nonneg;
      BR_J: begin
        cond   = 1'b1;
        target = {pc_d_plus4[31:28], instr_index, 2'b00};
      end
      BR_JR: begin
        cond   = 1'b1;
        target = {rs_data[31:2], 2'b00};
      end
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC register with MIPS single-delay-slot redirect. A redirect resolved
// while instruction memory is not ready is parked in pend_tgt and applied on
// the next fetch advance.
// Optional feature: PC_REDIRECT_EXC_VECTOR_EN adds exc_req, which forces the
// next fetch to EXC_PC regardless of stall, imem_ready or a pending redirect.
//
// state | meaning
// SEQ   | sequential fetch, redirects applied directly on fire
// PEND  | redirect captured in pend_tgt, waiting for fire
module pc_redirect_unit
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
`ifdef PC_REDIRECT_EXC_VECTOR_EN
  ,
  parameter logic [31:0] EXC_PC   = EXC_PC_DEF
`endif
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic        br_valid,
  input  logic [2:0]  br_type,
  input  logic        zero,
  input  logic        nonneg,
  input  logic [31:0] pc_d,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] rs_data,
`ifdef PC_REDIRECT_EXC_VECTOR_EN
  input  logic        exc_req,
`endif
  output logic [31:0] pc_f,
  output logic        taken,
  output logic        pend
);

  pc_state_t   state_q, state_n;
  logic [31:0] pc_q, pc_n;
  logic [31:0] tgt_q, tgt_n;
  logic        cond;
  logic [31:0] target;
  logic        resolve;
  logic        fire;

  br_target_gen u_tgt (
    .br_type     (br_type),
    .zero        (zero),
    .nonneg      (nonneg),
    .pc_d        (pc_d),
    .imm16       (imm16),
    .instr_index (instr_index),
    .rs_data     (rs_data),
    .cond        (cond),
    .target      (target)
  );

  assign resolve = br_valid && !stall;
  assign fire    = imem_ready && !stall;
  assign taken   = resolve && cond;

  // State, PC and pending-target registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SEQ;
      pc_q    <= RESET_PC;
      tgt_q   <= 32'd0;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
      tgt_q   <= tgt_n;
    end
  end

  // Next PC / next state; the current pc_f is the delay slot and is always
  // fetched before any redirect takes effect.
  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    tgt_n   = tgt_q;
    case (state_q)
      SEQ: begin
        if (fire) begin
          pc_n = taken ? target : pc_q + 32'd4;
        end else if (taken) begin
          tgt_n   = target;
          state_n = PEND;
        end
      end
      PEND: begin
        // ID holds a bubble here, so br_valid is ignored.
        if (fire) begin
          pc_n    = tgt_q;
          state_n = SEQ;
        end
      end
      default: state_n = SEQ;
    endcase
`ifdef PC_REDIRECT_EXC_VECTOR_EN
    if (exc_req) begin
      pc_n    = EXC_PC;
      state_n = SEQ;
    end
`endif
  end

  assign pc_f = pc_q;
  assign pend = (state_q == PEND);

`ifndef SYNTHESIS
  // A branch in ID while a redirect is pending means upstream broke the
  // bubble guarantee.
  a_no_branch_in_pend: assert property (
    @(posedge clk) disable iff (!reset_n) !(state_q == PEND && br_valid)
  );
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Self-checking bench for pc_redirect_unit: an independent reference model
// predicts pc_f/pend per cycle, the prediction is queued when stimulus is
// applied and popped/compared after the clock edge.
module tb_pc_redirect_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        imem_ready = 1'b0;
  logic        br_valid = 1'b0;
  logic [2:0]  br_type = 3'd0;
  logic        zero = 1'b0;
  logic        nonneg = 1'b0;
  logic [31:0] pc_d = 32'd0;
  logic [15:0] imm16 = 16'd0;
  logic [25:0] instr_index = 26'd0;
  logic [31:0] rs_data = 32'd0;
`ifdef PC_REDIRECT_EXC_VECTOR_EN
  logic        exc_req = 1'b0;
`endif
  logic [31:0] pc_f;
  logic        taken;
  logic        pend;

  pc_redirect_unit dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .stall       (stall),
    .imem_ready  (imem_ready),
    .br_valid    (br_valid),
    .br_type     (br_type),
    .zero        (zero),
    .nonneg      (nonneg),
    .pc_d        (pc_d),
    .imm16       (imm16),
    .instr_index (instr_index),
    .rs_data     (rs_data),
`ifdef PC_REDIRECT_EXC_VECTOR_EN
    .exc_req     (exc_req),
`endif
    .pc_f        (pc_f),
    .taken       (taken),
    .pend        (pend)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic        pend;
  } exp_t;
  exp_t sb[$];

  logic [31:0] m_pc  = 32'h0000_3000;
  logic        m_pend = 1'b0;
  logic [31:0] m_tgt = 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic ref_taken();
    logic t;
    if (!br_valid || stall) return 1'b0;
    case (br_type)
      3'd0: t = zero;
      3'd1: t = ~zero;
      3'd2: t = nonneg;
      3'd3: t = ~nonneg;
      3'd4, 3'd5: t = 1'b1;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic logic [31:0] ref_target();
    logic [31:0] nxt;
    nxt = pc_d + 32'd4;
    if (br_type == 3'd4) return (nxt & 32'hF000_0000) | ({6'd0, instr_index} << 2);
    if (br_type == 3'd5) return rs_data & 32'hFFFF_FFFC;
    return nxt + 32'($signed(imm16)) * 32'd4;
  endfunction

  // One clock: check taken, predict the post-edge state, clock, compare.
  task automatic step(input string tag);
    logic  t;
    logic  f;
    exp_t  e;
    #1;
    t = ref_taken();
    check({tag, ".taken"}, {31'd0, taken}, {31'd0, t});
    f = imem_ready && !stall;
    if (!m_pend) begin
      if (f) m_pc = t ? ref_target() : m_pc + 32'd4;
      else if (t) begin
        m_pend = 1'b1;
        m_tgt  = ref_target();
      end
    end else if (f) begin
      m_pc   = m_tgt;
      m_pend = 1'b0;
    end
`ifdef PC_REDIRECT_EXC_VECTOR_EN
    if (exc_req) begin
      m_pc   = 32'h0000_4180;
      m_pend = 1'b0;
    end
`endif
    sb.push_back('{pc: m_pc, pend: m_pend});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, ".pc_f"}, pc_f, e.pc);
      check({tag, ".pend"}, {31'd0, pend}, {31'd0, e.pend});
    end
  endtask

  task automatic set_br(input logic v, input logic [2:0] ty, input logic z, input logic nn);
    br_valid = v;
    br_type  = ty;
    zero     = z;
    nonneg   = nn;
  endtask

  task automatic model_reset();
    m_pc   = 32'h0000_3000;
    m_pend = 1'b0;
    m_tgt  = 32'd0;
  endtask

  initial begin
    // reset state
    imem_ready = 1'b1;
    #12;
    check("rst.pc_f", pc_f, 32'h0000_3000);
    check("rst.pend", {31'd0, pend}, 32'd0);
    imem_ready = 1'b0;
    reset_n    = 1'b1;
    @(posedge clk);
    #1;
    check("rst.hold", pc_f, 32'h0000_3000);

    // sequential fetch
    imem_ready = 1'b1;
    step("seq0");
    check("seq0.lit", pc_f, 32'h0000_3004);
    step("seq1");
    check("seq1.lit", pc_f, 32'h0000_3008);

    // BEQ taken backwards to itself
    pc_d  = 32'h0000_3000;
    imm16 = 16'hFFFF;
    set_br(1'b1, 3'd0, 1'b1, 1'b0);
    #1;
    check("beq.taken_lit", {31'd0, taken}, 32'd1);
    step("beq_t");
    check("beq_t.lit", pc_f, 32'h0000_3000);
    set_br(1'b0, 3'd0, 1'b0, 1'b0);
    step("seq2");
    set_br(1'b1, 3'd0, 1'b0, 1'b0);
    step("beq_nt");
    check("beq_nt.lit", pc_f, 32'h0000_3008);

    // BGEZ / BLTZ with negative rs
    pc_d  = 32'h0000_3010;
    imm16 = 16'h0008;
    set_br(1'b1, 3'd2, 1'b0, 1'b0);
    step("bgez_nt");
    set_br(1'b1, 3'd3, 1'b0, 1'b0);
    step("bltz_t");
    check("bltz_t.lit", pc_f, 32'h0000_3034);

    // BNE with equal operands, reserved type
    set_br(1'b1, 3'd1, 1'b1, 1'b1);
    step("bne_nt");
    set_br(1'b1, 3'd6, 1'b1, 1'b1);
    step("rsvd");

    // J and JR
    pc_d        = 32'h0000_3010;
    instr_index = 26'h0000C01;
    set_br(1'b1, 3'd4, 1'b0, 1'b0);
    step("j");
    check("j.lit", pc_f, 32'h0000_3004);
    rs_data = 32'h0000_400E;
    set_br(1'b1, 3'd5, 1'b0, 1'b0);
    step("jr");
    check("jr.lit", pc_f, 32'h0000_400C);

    // pc + 4 wraps to zero
    rs_data = 32'hFFFF_FFFF;
    step("jr_top");
    set_br(1'b0, 3'd0, 1'b0, 1'b0);
    step("wrap");
    check("wrap.lit", pc_f, 32'h0000_0000);

    // taken branch while imem not ready -> pending redirect
    pc_d       = 32'h0000_3100;
    imm16      = 16'h0010;
    imem_ready = 1'b0;
    set_br(1'b1, 3'd0, 1'b1, 1'b0);
    step("pend_cap");
    set_br(1'b0, 3'd0, 1'b0, 1'b0);
    step("pend_h1");
    step("pend_h2");
    check("pend.hold_lit", {31'd0, pend}, 32'd1);
    imem_ready = 1'b1;
    step("pend_apply");
    check("pend.apply_lit", pc_f, 32'h0000_3144);

    // stall dominates: no resolution, no fetch update
    stall = 1'b1;
    set_br(1'b1, 3'd0, 1'b1, 1'b0);
    #1;
    check("stall.taken_lit", {31'd0, taken}, 32'd0);
    step("stall_br");
    set_br(1'b0, 3'd0, 1'b0, 1'b0);
    stall = 1'b0;

    // stall holds a pending redirect
    imem_ready = 1'b0;
    set_br(1'b1, 3'd4, 1'b0, 1'b0);
    step("pend2_cap");
    set_br(1'b0, 3'd0, 1'b0, 1'b0);
    stall      = 1'b1;
    imem_ready = 1'b1;
    step("pend2_stall");
    stall = 1'b0;
    step("pend2_apply");

    // reset in the middle of PEND
    imem_ready = 1'b0;
    pc_d       = 32'h0000_3200;
    set_br(1'b1, 3'd0, 1'b1, 1'b0);
    step("pend3_cap");
    set_br(1'b0, 3'd0, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_pend.pc_f", pc_f, 32'h0000_3000);
    check("rst_pend.pend", {31'd0, pend}, 32'd0);
    model_reset();
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_pend.hold", pc_f, 32'h0000_3000);

`ifdef PC_REDIRECT_EXC_VECTOR_EN
    // exception overrides PEND and stall
    set_br(1'b1, 3'd0, 1'b1, 1'b0);
    step("exc_cap");
    set_br(1'b0, 3'd0, 1'b0, 1'b0);
    stall   = 1'b1;
    exc_req = 1'b1;
    step("exc");
    check("exc.lit", pc_f, 32'h0000_4180);
    exc_req = 1'b0;
    stall   = 1'b0;
`endif

    // random mix; never present a branch while a redirect is pending
    for (int i = 0; i < 60; i++) begin
      stall       = ($urandom_range(0, 3) == 0);
      imem_ready  = ($urandom_range(0, 9) < 7);
      pc_d        = $urandom;
      imm16       = 16'($urandom);
      instr_index = 26'($urandom);
      rs_data     = $urandom;
      set_br(m_pend ? 1'b0 : 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      step($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_redirect_unit.md
# pc_redirect_unit

Fetch-side program-counter unit: the consumer of the ID-stage comparator flags (`zero`, `nonneg`). It resolves branch and jump outcomes for the instruction in ID, computes the target, and steers the IF-stage PC with MIPS single-delay-slot semantics. Fetch may be held by the hazard unit (`stall`) or by a slow instruction memory (`imem_ready`); a resolved redirect that cannot be applied immediately is held in a pending register until fetch advances.

## Interface
- `RESET_PC`, default 32'h0000_3000: value of `pc_f` after reset.
- `EXC_PC`, default 32'h0000_4180: exception vector (used only with `EXC_VECTOR_EN`).
- `clk`  in  1: single clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `stall`  in  1: hazard-unit stall; holds IF and ID, no resolution.
- `imem_ready`  in  1: instruction memory returns the word at `pc_f` this cycle.
- `br_valid`  in  1: ID holds a branch/jump.
- `br_type`  in  3: 0 BEQ, 1 BNE, 2 BGEZ, 3 BLTZ, 4 J/JAL, 5 JR/JALR, 6–7 reserved.
- `zero`  in  1: comparator, rs == rt.
- `nonneg`  in  1: comparator, rs[31] == 0.
- `pc_d`  in  32: PC of the ID-stage instruction.
- `imm16`  in  16: branch offset field.
- `instr_index`  in  26: jump index field.
- `rs_data`  in  32: forwarded rs value for JR.
- `exc_req`  in  1: exception redirect (`EXC_VECTOR_EN` only).
- `pc_f`  out  32: fetch address.
- `taken`  out  1: combinational; branch resolved taken this cycle.
- `pend`  out  1: registered; redirect captured, not yet applied.

## Operation
- `resolve` = `br_valid` && !`stall`. `fire` = `imem_ready` && !`stall`.
- `taken`: BEQ `zero`; BNE !`zero`; BGEZ `nonneg`; BLTZ !`nonneg`; J and JR always; reserved types 0. Forced 0 when !`resolve`.
- Targets, all modulo 2^32:
  - Branch: `pc_d` + 4 + (sext(`imm16`) << 2).
  - J: {(`pc_d`+4)[31:28], `instr_index`, 2'b00}.
  - JR: {`rs_data`[31:2], 2'b00}.
- During resolution `pc_f` is the delay slot. It is always fetched; the redirect applies to the fetch after it.
- State SEQ:
  - `fire` && `taken` → `pc_f` <= target, stay SEQ.
  - `fire` && !`taken` → `pc_f` <= `pc_f` + 4.
  - !`fire` && `taken` (`imem_ready` low) → hold `pc_f`, latch target into `pend_tgt`, go PEND.
  - Otherwise hold `pc_f`.
- State PEND:
  - `fire` → `pc_f` <= `pend_tgt`, go SEQ.
  - Otherwise hold.
  - `br_valid` in PEND is a protocol violation (ID holds a bubble). It is ignored and flagged by a simulation-only assertion.
- Reset, at any time including mid-PEND: `pc_f` = `RESET_PC`, state SEQ, `pend` = 0, `pend_tgt` = 0.

## Timing
- `taken` is combinational from the inputs, same cycle.
- `pc_f` updates on the edge ending the `fire` cycle (1-cycle latency from resolution when `imem_ready` = 1).
- A pending redirect applies on the first `fire` edge after capture. The minimum is 2 cycles after resolution.
- `stall` dominates `imem_ready`: no update and no capture while `stall` = 1.
- The pc + 4 wrap from 32'hFFFF_FFFC gives 0. There is no trap.

## Configuration
- `PC_REDIRECT_EXC_VECTOR_EN` defined:
  - `exc_req` = 1 overrides everything, including `stall`, `imem_ready` and PEND.
  - Next edge: `pc_f` <= `EXC_PC`, state SEQ, `pend` = 0.
- Undefined: the `exc_req` port is absent and `EXC_PC` is unused.

## Structure
- Package `pc_pkg`: `br_type` encodings (`BR_BEQ` … `BR_JR`), state enum {`SEQ`, `PEND`}, default `RESET_PC` and `EXC_PC` constants.
- One sub-module `br_target_gen`: purely combinational taken/target computation from `br_type`, flags, `pc_d`, `imm16`, `instr_index` and `rs_data`. The top level holds the PC register and the FSM.

## Test plan
- Reset: hold `reset_n` = 0 → `pc_f` = 32'h3000, `pend` = 0. Release with `imem_ready` = 1 and no branch → `pc_f` goes 3004, then 3008.
- BEQ, `pc_d` = 3000, `imm16` = 16'hFFFF, `zero` = 1, `imem_ready` = 1:
  - `taken` = 1 in the resolution cycle.
  - Next `pc_f` = 32'h3000.
  - Same stimulus with `zero` = 0 → `pc_f` = 3008.
- BGEZ with `nonneg` = 0 → not taken. BLTZ with `nonneg` = 0 → taken. J with `pc_d` = 3010, `instr_index` = 26'h0C01 → `pc_f` = 32'h3004.
- JR with `rs_data` = 32'h0000_400E → `pc_f` = 32'h0000_400C.
- Taken branch while `imem_ready` = 0:
  - `pend` = 1 and `pc_f` held for 3 cycles.
  - On the `imem_ready` rise, `pc_f` = target and `pend` = 0.
  - Assert `reset_n` mid-PEND → `pc_f` = 3000, `pend` = 0.
- `stall` = 1 with `br_valid` = 1 and `zero` = 1 → `taken` = 0, `pc_f` unchanged. With `EXC_VECTOR_EN`, `exc_req` during PEND → `pc_f` = 32'h4180, `pend` = 0.
